// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control, instruction-memory read port, IR handshake to decode
// and the redirect path from execute.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
) ();
  logic              run;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic              ir_enable;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    input  run, imem_instr, ir_ready, redirect_valid, redirect_pc,
    output imem_addr, ir_enable, ir_out, ir_pc, ir_valid
  );

  modport slave (
    output run, imem_instr, ir_ready, redirect_valid, redirect_pc,
    input  imem_addr, ir_enable, ir_out, ir_pc, ir_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR with valid/ready to decode, predecoded unconditional
// jumps and redirects from execute.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [3:0]        JUMP_OP  = 4'b1011,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset_n,
  fetch_unit_if.master bus
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFetch = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              valid_q, valid_d;
  logic              load;
  logic              is_jump;

  assign is_jump = (bus.imem_instr[DATA_W-1 -: 4] == JUMP_OP);

  always_comb begin
    load    = (state_q == StFetch) && bus.run && !bus.redirect_valid &&
              (!valid_q || bus.ir_ready);
    state_d = bus.run ? StFetch : StIdle;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    // Redirect overrides everything, including a jump being predecoded this cycle.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
    end else if (load) begin
      ir_d    = bus.imem_instr;
      ir_pc_d = pc_q;
      valid_d = 1'b1;
      pc_d    = is_jump ? bus.imem_instr[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end else if (bus.ir_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.ir_enable = load;
  assign bus.ir_out    = ir_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.ir_valid  = valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the 16-entry instruction memory and downstream-facing to decode. Holds the program counter, drives the memory address, latches the returned word into an instruction register (IR) and hands it to decode over a valid/ready handshake. Resolves unconditional jumps locally by predecoding the fetched opcode, and accepts a redirect from execute for taken branches.

## Interface
- `ADDR_W`, default 4: PC and memory address width; 16 instructions.
- `DATA_W`, default 16: instruction width.
- `JUMP_OP`, default 4'b1011: opcode in `instr[15:12]` predecoded as an unconditional jump.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: fetch enable from the control path.
- `imem_addr`, out, ADDR_W: address to the instruction memory; equals PC.
- `imem_instr`, in, DATA_W: combinational read data from the instruction memory.
- `ir_enable`, out, 1: high in cycles where the IR loads; drives memory `IR_enable`.
- `ir_out`, out, DATA_W: latched instruction to decode.
- `ir_pc`, out, ADDR_W: address `ir_out` was fetched from.
- `ir_valid`, out, 1: `ir_out` holds an unconsumed instruction.
- `ir_ready`, in, 1: decode accepts `ir_out` this cycle.
- `redirect_valid`, in, 1: execute requests a PC change (taken branch) and a flush.
- `redirect_pc`, in, ADDR_W: redirect target.

## Operation
- States: IDLE (no fetching) and FETCH.
- Reset: state IDLE, PC = RESET_PC, `ir_out` = 0, `ir_pc` = 0, `ir_valid` = 0. `ir_enable` = 0 and `imem_addr` = RESET_PC.
- IDLE goes to FETCH on the edge where `run` = 1. FETCH goes to IDLE on the edge where `run` = 0. A fetch is not performed on that edge.
- A load occurs in FETCH when `run` = 1, `redirect_valid` = 0, and `ir_valid` = 0 or `ir_ready` = 1. It does the following:
  - `ir_out` = `imem_instr`, `ir_pc` = PC, `ir_valid` = 1.
  - `ir_enable` is high combinationally in that cycle.
- PC after a load:
  - If `imem_instr[15:12]` = JUMP_OP, PC = `imem_instr[ADDR_W-1:0]` (jump target).
  - Otherwise PC = PC+1, modulo 2^ADDR_W, so 15 wraps to 0.
  - A jump is still delivered to decode as a normal instruction.
- Stall: when `ir_valid` = 1 and `ir_ready` = 0, the IR, `ir_pc`, `ir_valid` and PC all hold.
- Consume without refill: when `ir_ready` = 1 and no load occurs (IDLE, or `run` = 0), `ir_valid` goes to 0.
- Redirect: `redirect_valid` = 1 has highest priority, in any state, stalled or not.
  - PC = `redirect_pc`, `ir_valid` = 0 (flush), no load, `ir_enable` = 0.
  - The state follows `run`.
- Simultaneous events:
  - Redirect plus a predecoded jump: redirect wins and the jump is discarded.
  - Redirect plus `ir_ready`: flush; the handshake is ignored.
  - Redirect plus `run` falling: PC is updated and state goes to IDLE.
- Reset mid-stream: asynchronous return to all reset values; any in-flight IR contents are discarded.

## Timing
- `imem_addr` is the PC register output with no combinational path from inputs.
- Latency: PC presented in cycle n gives `ir_out`/`ir_valid` at the edge ending cycle n.
  - Fetch is possible in the first FETCH cycle after IDLE, so the first instruction appears 2 edges after `run` rises.
- Throughput: one instruction per cycle while `ir_ready` = 1.
- Predecoded jump: no bubble; the target word is fetched in the very next cycle.
- Redirect: one bubble. The edge with redirect clears `ir_valid`; the next edge loads `mem[redirect_pc]`.
- A handshake completes on an edge with `ir_valid` & `ir_ready` both high.
- `ir_out` is stable while `ir_valid` = 1 and `ir_ready` = 0.

## Test plan
- Reset and start:
  - Assert `reset_n` = 0 mid-cycle, then `run` = 1 with `ir_ready` = 1 and mem[0..3] = 0x0000, 0xA016, 0x9516, 0x6587.
  - Required: all outputs at reset values asynchronously.
  - Then `ir_out` = 0x0000, 0xA016, 0x9516, 0x6587 on consecutive edges, with `ir_pc` = 0..3.
- Predecoded jump:
  - mem[4] = 0xB000.
  - Required: `ir_out` = 0xB000 with `ir_pc` = 4, next `ir_pc` = 0, no bubble.
  - With mem[7] = 0xB003, the next `ir_pc` after 7 is 3.
- Stall:
  - Hold `ir_ready` = 0 for 3 cycles while `ir_out` = 0xA016 (`ir_pc` = 1).
  - Required: `ir_out`, `ir_pc`, `imem_addr` = 2 and `ir_valid` all constant, with `ir_enable` = 0.
  - On release, 0x9516 is delivered on the next edge.
- Redirect while stalled:
  - Apply `redirect_valid` = 1 with `redirect_pc` = 9 during a stall.
  - Required: `ir_valid` = 0 next edge, `imem_addr` = 9, then `ir_pc` = 9 one edge later.
  - Redirect plus a simultaneous jump fetch: the jump target is ignored.
- Wrap:
  - Fill mem with non-jump words and run from 14.
  - Required: `ir_pc` sequence 14, 15, 0, 1.
- Run drop and reset mid-stream:
  - Drop `run` with `ir_valid` = 1 and `ir_ready` = 1.
  - Required: `ir_valid` goes to 0 and PC holds.
  - Pull `reset_n` low during a fetch: PC = 0 and `ir_valid` = 0 immediately.
